// File: rtl/sum_every3_pkg.sv
// rtl/sum_every3_pkg.sv - shared defaults and width helpers for sum_every3
package sum_every3_pkg;

    // Default sample width and group size.
    localparam int IW_DEF = 8;
    localparam int N_DEF  = 3;

    // Sum width: enough headroom for N full-scale samples, so the sum never wraps.
    function automatic int calc_ow(input int iw, input int n);
        return iw + $clog2(n + 1);
    endfunction

    // Group counter width; N >= 2 keeps this at least one bit.
    function automatic int calc_cw(input int n);
        return $clog2(n);
    endfunction

    localparam int OW_DEF = calc_ow(IW_DEF, N_DEF);
    localparam int CW_DEF = calc_cw(N_DEF);

endpackage

// File: rtl/sum_every3_cnt.sv
// rtl/sum_every3_cnt.sv - modulo-N group position counter with last flag
module sum_every3_cnt
    import sum_every3_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_last
);

    localparam int CW = calc_cw(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] r_cnt;

    // Advance once per accepted sample, wrapping after the final sample of a group.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/sum_every3.sv
// rtl/sum_every3.sv - streaming reducer emitting one sum per group of N valid samples
module sum_every3
    import sum_every3_pkg::*;
#(
    parameter int IW = IW_DEF,
    parameter int N  = N_DEF,
    parameter int OW = calc_ow(IW, N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_dval,
    input  logic [IW-1:0] i,
    output logic          o_dval,
    output logic [OW-1:0] o
);

    logic          w_last;
    logic [OW-1:0] w_sample;
    logic [OW-1:0] r_acc;
    logic [OW-1:0] r_o;
    logic          r_o_dval;

    // Zero-extend the sample; it is only ever added when i_dval is high,
    // so an undefined idle-cycle sample never reaches the accumulator.
    assign w_sample = OW'(i);

    sum_every3_cnt #(
        .N (N)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_en   (i_dval),
        .o_last (w_last)
    );

    // Accumulate the partial group; on the closing sample publish the sum and restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_o      <= '0;
            r_o_dval <= 1'b0;
        end else begin
            r_o_dval <= 1'b0;
            if (i_dval) begin
                if (w_last) begin
                    r_o      <= r_acc + w_sample;
                    r_o_dval <= 1'b1;
                    r_acc    <= '0;
                end else begin
                    r_acc <= r_acc + w_sample;
                end
            end
        end
    end

    assign o      = r_o;
    assign o_dval = r_o_dval;

endmodule

// File: tb/tb_sum_every3.sv
// tb/tb_sum_every3.sv - scoreboard bench for sum_every3
module tb_sum_every3;

    logic       clk;
    logic       rst;
    logic       i_dval;
    logic [7:0] i;
    logic       o_dval;
    logic [9:0] o;

    typedef struct {
        int sum;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc       = 0;
    logic rst_q     = 1'b1;
    int   n_pass    = 0;
    int   n_total   = 0;
    int   n_pulses  = 0;
    int   n_pushed  = 0;
    int   m_cnt     = 0;
    int   m_sum     = 0;
    int   n_valid   = 0;

    sum_every3 dut (
        .clk    (clk),
        .rst    (rst),
        .i_dval (i_dval),
        .i      (i),
        .o_dval (o_dval),
        .o      (o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every output pulse against the scoreboard head.
    always @(negedge clk) begin
        if (rst_q) begin
            chk("reset_o", int'(o), 0);
            chk("reset_o_dval", int'(o_dval), 0);
        end else if (o_dval) begin
            n_pulses++;
            if (q.size() == 0) begin
                chk("spurious_pulse", int'(o_dval), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sum", int'(o), e.sum);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            void'(q.pop_front());
            chk("missed_pulse", int'(o_dval), 1);
        end
    end

    // Drive one cycle; when exp >= 0 the sample closes a group with that hand-computed sum.
    task automatic send(input logic v, input int d, input int exp);
        i_dval = v;
        i      = v ? 8'(d) : 8'bx;
        if (exp >= 0) begin
            exp_t e;
            e.sum = exp;
            e.cyc = cyc + 1;
            q.push_back(e);
            n_pushed++;
        end
        @(posedge clk);
        #1;
    endtask

    // Random-stream driver: the reference sum is formed from the samples themselves.
    task automatic send_model(input logic v, input int d);
        int e;
        e = -1;
        if (v) begin
            n_valid++;
            m_sum += d;
            m_cnt++;
            if (m_cnt == 3) begin
                e     = m_sum;
                m_sum = 0;
                m_cnt = 0;
            end
        end
        send(v, d, e);
    endtask

    task automatic do_reset(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            rst    = 1'b1;
            i_dval = 1'($urandom_range(1));
            i      = 8'($urandom_range(255));
            @(posedge clk);
            #1;
        end
        rst    = 1'b0;
        i_dval = 1'b0;
        m_cnt  = 0;
        m_sum  = 0;
    endtask

    initial begin
        rst    = 1'b1;
        i_dval = 1'b0;
        i      = 8'd0;
        @(posedge clk);
        #1;

        // Reset with random inputs, then one idle cycle after release.
        do_reset(5);
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_o", int'(o), 0);
        chk("post_reset_o_dval", int'(o_dval), 0);
        @(posedge clk);
        #1;

        // Back-to-back 1..6.
        send(1'b1, 1, -1);
        send(1'b1, 2, -1);
        send(1'b1, 3, 6);
        send(1'b1, 4, -1);
        send(1'b1, 5, -1);
        send(1'b1, 6, 15);
        send(1'b0, 0, -1);

        // Idle gaps inside a group.
        send(1'b1, 10, -1);
        send(1'b0, 0, -1);
        send(1'b0, 0, -1);
        send(1'b1, 20, -1);
        send(1'b0, 0, -1);
        send(1'b1, 30, 60);
        send(1'b0, 0, -1);

        // Full-scale samples.
        send(1'b1, 255, -1);
        send(1'b1, 255, -1);
        send(1'b1, 255, 765);
        send(1'b0, 0, -1);
        send(1'b0, 0, -1);

        // Reset mid-group discards 7 and 8.
        send(1'b1, 7, -1);
        send(1'b1, 8, -1);
        rst    = 1'b1;
        i_dval = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(1'b1, 1, -1);
        send(1'b1, 1, -1);
        send(1'b1, 1, 3);
        send(1'b0, 0, -1);

        // Random stream from a clean start.
        do_reset(2);
        n_valid = 0;
        for (int k = 0; k < 1000; k++) begin
            send_model(1'($urandom_range(1)), int'($urandom_range(255)));
        end
        send(1'b0, 0, -1);
        send(1'b0, 0, -1);
        send(1'b0, 0, -1);

        chk("queue_drained", q.size(), 0);
        chk("pulse_count", n_pulses, n_pushed);
        chk("random_valid_triples", n_pushed - 5, n_valid / 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
